// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port between the instruction and data
// requesters of two cores. A round-robin pointer picks the core and data
// wins over instruction within a core. The grant is held until the RAM
// completes, errors, times out or the request is withdrawn.
module ram_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        iREN,
  input  logic [1:0]        dREN,
  input  logic [1:0]        dWEN,
  input  logic [1:0][31:0]  iaddr,
  input  logic [1:0][31:0]  daddr,
  input  logic [1:0][31:0]  dstore,
  output logic [1:0]        iwait,
  output logic [1:0]        dwait,
  output logic [1:0][31:0]  iload,
  output logic [1:0][31:0]  dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [31:0]       ramaddr,
  output logic [31:0]       ramstore,
  input  logic [31:0]       ramload,
  input  logic [1:0]        ramstate,
  output logic              tmo,
  output logic              err
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    GNT  = 1'b1
  } state_e;

  state_e           state, state_nxt;
  logic             core, core_nxt;      // granted core
  logic             is_data, data_nxt;   // granted requester is the data port
  logic             rr, rr_nxt;          // core favoured when both compete
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             tmo_nxt, err_nxt;

  logic [1:0]       act;
  logic             win_core;
  logic             win_data;
  logic             req_live;

  // Every core sees the RAM read bus directly; wait bits qualify it.
  assign iload = {ramload, ramload};
  assign dload = {ramload, ramload};

  // Arbitration among the cores that have any requester active.
  always_comb begin
    act      = dREN | dWEN | iREN;
    win_core = (act[0] && act[1]) ? rr : act[1];
    win_data = dREN[win_core] | dWEN[win_core];
    req_live = is_data ? (dREN[core] | dWEN[core]) : iREN[core];
  end

  // Next-state, RAM strobes and per-core wait generation.
  always_comb begin
    state_nxt = state;
    core_nxt  = core;
    data_nxt  = is_data;
    rr_nxt    = rr;
    cnt_nxt   = cnt;
    tmo_nxt   = 1'b0;
    err_nxt   = 1'b0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = 32'd0;
    ramstore  = 32'd0;
    iwait     = 2'b11;
    dwait     = 2'b11;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (|act) begin
          state_nxt = GNT;
          core_nxt  = win_core;
          data_nxt  = win_data;
        end
      end

      GNT: begin
        if (is_data) begin
          // A simultaneous read and write is presented as a write.
          ramWEN   = dWEN[core];
          ramREN   = dREN[core] & ~dWEN[core];
          ramaddr  = daddr[core];
          ramstore = dstore[core];
        end else begin
          ramREN   = iREN[core];
          ramaddr  = iaddr[core];
        end

        cnt_nxt = cnt + CNT_W'(1);

        if (!req_live) begin
          state_nxt = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          if (is_data) begin
            dwait[core] = 1'b0;
          end else begin
            iwait[core] = 1'b0;
          end
          state_nxt = IDLE;
          rr_nxt    = ~core;
        end else if (ramstate == RAM_ERROR) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
          rr_nxt    = ~core;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          tmo_nxt   = 1'b1;
          rr_nxt    = ~core;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      core    <= 1'b0;
      is_data <= 1'b0;
      rr      <= 1'b0;
      cnt     <= '0;
      tmo     <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      core    <= core_nxt;
      is_data <= data_nxt;
      rr      <= rr_nxt;
      cnt     <= cnt_nxt;
      tmo     <= tmo_nxt;
      err     <= err_nxt;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small latency-configurable RAM model.
module tb_ram_arbiter;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [1:0]        iREN, dREN, dWEN;
  logic [1:0][31:0]  iaddr, daddr, dstore;
  logic [1:0]        iwait, dwait;
  logic [1:0][31:0]  iload, dload;
  logic              ramREN, ramWEN;
  logic [31:0]       ramaddr, ramstore, ramload;
  logic [1:0]        ramstate;
  logic              tmo, err;

  int checks = 0;
  int errors = 0;

  // RAM model: mode 0 = completes after lat cycles, 1 = stuck BUSY, 2 = ERROR
  int          mode = 0;
  int          lat = 1;
  int          lat_cnt = 0;
  logic [31:0] mem [0:63];

  ram_arbiter #(.TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .tmo(tmo), .err(err)
  );

  always #5 CLK = ~CLK;

  assign ramload = mem[ramaddr[7:2]];

  // RAM status as seen by the arbiter this cycle.
  always_comb begin
    ramstate = FREE;
    if (ramREN || ramWEN) begin
      if (mode == 1)                ramstate = BUSY;
      else if (mode == 2)           ramstate = ERROR;
      else if (lat_cnt == lat - 1)  ramstate = ACCESS;
      else                          ramstate = BUSY;
    end
  end

  // RAM latency counter and write port.
  always @(posedge CLK) begin
    if ((ramREN || ramWEN) && ramstate != ACCESS) lat_cnt <= lat_cnt + 1;
    else                                          lat_cnt <= 0;
    if (ramstate == ACCESS && ramWEN) mem[ramaddr[7:2]] <= ramstore;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the given requester's wait bit to drop; returns the
  // negedge index it dropped on (0 if never) and the load value seen then.
  task automatic wait_done(input bit is_d, input int c, input int maxc,
                           output int cyc, output logic [31:0] ld);
    cyc = 0;
    ld  = 32'hx;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge CLK);
      chk("wait_onehot", 32'($countones(~{iwait, dwait}) <= 1), 32'd1);
      if (is_d ? !dwait[c] : !iwait[c]) begin
        cyc = i;
        ld  = is_d ? dload[c] : iload[c];
        break;
      end
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    int          cyc;
    logic [31:0] ld;
    int          g;
    int          ec;

    iREN = 2'b00; dREN = 2'b00; dWEN = 2'b00;
    iaddr = '0; daddr = '0; dstore = '0;

    // Reset state
    @(negedge CLK);
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("rst_waits", 32'({iwait, dwait}), 32'hF);
    chk("rst_tmo_err", 32'({tmo, err}), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // Core0 write with 2-cycle RAM, then instruction readback
    lat = 2;
    dWEN = 2'b01; daddr[0] = 32'h10; dstore[0] = 32'hDEADBEEF;
    wait_done(1'b1, 0, 10, cyc, ld);
    chk("t1_wr_cycles", 32'(cyc), 32'd3);
    dWEN = 2'b00;
    iREN = 2'b01; iaddr[0] = 32'h10;
    wait_done(1'b0, 0, 10, cyc, ld);
    chk("t1_rd_cycles", 32'(cyc), 32'd3);
    chk("t1_iload", ld, 32'hDEADBEEF);
    iREN = 2'b00;

    // Core1 writes 0xFEEDFEED to 0x14
    dWEN = 2'b10; daddr[1] = 32'h14; dstore[1] = 32'hFEEDFEED;
    wait_done(1'b1, 1, 10, cyc, ld);
    chk("t2_prep_cycles", 32'(cyc), 32'd3);
    dWEN = 2'b00;

    // Core0 data and instruction together: data first
    dREN = 2'b01; iREN = 2'b01; daddr[0] = 32'h14;
    wait_done(1'b1, 0, 10, cyc, ld);
    chk("t2_data_cycles", 32'(cyc), 32'd3);
    chk("t2_dload", ld, 32'hFEEDFEED);
    dREN = 2'b00;
    wait_done(1'b0, 0, 10, cyc, ld);
    chk("t2_instr_cycles", 32'(cyc), 32'd3);
    chk("t2_iload", ld, 32'hDEADBEEF);
    iREN = 2'b00;

    // Both cores continuous: alternating grants starting at core 0
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    lat = 1;
    daddr[0] = 32'h10; daddr[1] = 32'h14;
    dREN = 2'b11;
    g = 0; ec = 0;
    for (int i = 0; i < 20 && g < 6; i++) begin
      @(negedge CLK);
      chk("t3_onehot", 32'($countones(~{iwait, dwait}) <= 1), 32'd1);
      if (dwait != 2'b11) begin
        chk("t3_grant", 32'(dwait), (ec == 0) ? 32'h2 : 32'h1);
        g++;
        ec ^= 1;
      end
    end
    chk("t3_grant_count", 32'(g), 32'd6);
    @(posedge CLK); #1;
    dREN = 2'b00;
    @(posedge CLK); #1;

    // Stuck BUSY: timeout after 8 grant cycles, then the other core
    mode = 1;
    dREN = 2'b11;
    for (int i = 1; i <= 11; i++) begin
      @(negedge CLK);
      chk("t4_waits", 32'({iwait, dwait}), 32'hF);
      chk("t4_tmo", 32'(tmo), (i == 10) ? 32'd1 : 32'd0);
      if (i == 2)  chk("t4_first_addr", ramaddr, 32'h10);
      if (i == 11) chk("t4_next_addr", ramaddr, 32'h14);
    end
    @(posedge CLK); #1;
    dREN = 2'b00;
    mode = 0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;

    // ERROR during a core1 write
    mode = 2;
    dWEN = 2'b10; daddr[1] = 32'h20; dstore[1] = 32'h12345678;
    @(negedge CLK);
    chk("t5_err_idle", 32'(err), 32'd0);
    @(negedge CLK);
    chk("t5_gnt_wen", 32'(ramWEN), 32'd1);
    chk("t5_gnt_dwait", 32'(dwait), 32'h3);
    @(posedge CLK); #1;
    dWEN = 2'b00;
    @(negedge CLK);
    chk("t5_err_pulse", 32'(err), 32'd1);
    chk("t5_dwait", 32'(dwait), 32'h3);
    chk("t5_back_idle", 32'(ramWEN), 32'd0);
    @(negedge CLK);
    chk("t5_err_end", 32'(err), 32'd0);
    mode = 0;
    @(posedge CLK); #1;

    // Core0 completes so the pointer favours core1, then reset mid-grant
    dREN = 2'b01;
    wait_done(1'b1, 0, 10, cyc, ld);
    chk("t6_pre_cycles", 32'(cyc), 32'd2);
    dREN = 2'b00;
    lat = 3;
    dWEN = 2'b10;
    @(negedge CLK);
    @(negedge CLK);
    chk("t6_gnt_wen", 32'(ramWEN), 32'd1);
    #2 RST = 1'b1;
    #1;
    chk("t6_rst_strobes", 32'({ramREN, ramWEN}), 32'd0);
    chk("t6_rst_waits", 32'({iwait, dwait}), 32'hF);
    @(posedge CLK); #1;
    RST = 1'b0;
    dWEN = 2'b00;
    dREN = 2'b11;
    @(negedge CLK);
    @(negedge CLK);
    chk("t6_first_core0", ramaddr, 32'h10);
    chk("t6_tmo", 32'(tmo), 32'd0);
    dREN = 2'b00;
    @(posedge CLK); #1;
    @(posedge CLK); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
